// File: rtl/wb_addr_decoder_if.sv
// Bus bundle for wb_addr_decoder: upstream Wishbone classic port plus the
// shared downstream request and per-slave responses.
interface wb_addr_decoder_if;
  localparam int unsigned ADR_W = 36;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned N_SLV = 4;

  logic [ADR_W-1:0]       wb_adr_i;
  logic [DAT_W-1:0]       wb_dat_i;
  logic [SEL_W-1:0]       wb_sel_i;
  logic                   wb_we_i;
  logic                   wb_stb_i;
  logic                   wb_cyc_i;
  logic [DAT_W-1:0]       wb_dat_o;
  logic                   wb_ack_o;

  logic [ADR_W-1:0]       s_adr_o;
  logic [DAT_W-1:0]       s_dat_o;
  logic [SEL_W-1:0]       s_sel_o;
  logic                   s_we_o;
  logic [N_SLV-1:0]       s_stb_o;
  logic [N_SLV-1:0]       s_cyc_o;
  logic [N_SLV*DAT_W-1:0] s_dat_i;
  logic [N_SLV-1:0]       s_ack_i;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    input  s_dat_i, s_ack_i
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/wb_addr_decoder.sv
// Wishbone address decoder: routes upstream accesses to one of four slaves by
// adr[35:34], plus an internal STAT register. Timeout logic under WB_DECODER_TIMEOUT_EN.
module wb_addr_decoder #(
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd64,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic               clk,
  input  logic               reset_n,
  wb_addr_decoder_if.slave   bus
);
  localparam int unsigned ADR_W = 36;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned N_SLV = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned ECW   = 16;
  localparam logic [ADR_W-1:0] STAT_ADR = 36'hF_FFFF_FFF0;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [ADR_W-1:0] r_adr, w_adr_nxt;
  logic [DAT_W-1:0] r_dat, w_dat_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic             r_we, w_we_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_SLV-1:0] r_stb, w_stb_nxt;
  logic             r_ack, w_ack_nxt;
  logic [DAT_W-1:0] r_wb_dat, w_wb_dat_nxt;
  logic [DAT_W-1:0] w_stat_val;
  logic             w_is_stat;
  logic [IDX_W-1:0] w_req_idx;

  assign w_is_stat = (bus.wb_adr_i == STAT_ADR);
  assign w_req_idx = bus.wb_adr_i[ADR_W-1 -: IDX_W];

`ifdef WB_DECODER_TIMEOUT_EN
  logic [7:0]       r_tmo_cnt, w_tmo_cnt_nxt;
  logic             r_err, w_err_nxt;
  logic [ECW-1:0]   r_err_cnt, w_err_cnt_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;

  assign w_stat_val = {r_err_cnt, 11'b0, r_last, 2'b0, r_err};
`else
  logic w_unused_cfg;

  assign w_stat_val   = '0;
  assign w_unused_cfg = ^{TIMEOUT_CYCLES, ERR_DATA, ECW};
`endif

  // Next-state and datapath update
  always_comb begin
    w_state_nxt  = r_state;
    w_adr_nxt    = r_adr;
    w_dat_nxt    = r_dat;
    w_sel_nxt    = r_sel;
    w_we_nxt     = r_we;
    w_idx_nxt    = r_idx;
    w_stb_nxt    = r_stb;
    w_ack_nxt    = 1'b0;
    w_wb_dat_nxt = r_wb_dat;
`ifdef WB_DECODER_TIMEOUT_EN
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_err_nxt     = r_err;
    w_err_cnt_nxt = r_err_cnt;
    w_last_nxt    = r_last;
`endif
    case (r_state)
      IDLE: begin
        if (bus.wb_cyc_i && bus.wb_stb_i) begin
          w_adr_nxt = bus.wb_adr_i;
          w_dat_nxt = bus.wb_dat_i;
          w_sel_nxt = bus.wb_sel_i;
          w_we_nxt  = bus.wb_we_i;
          w_idx_nxt = w_req_idx;
          if (w_is_stat) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = ACTIVE;
            w_stb_nxt   = N_SLV'(1) << w_req_idx;
`ifdef WB_DECODER_TIMEOUT_EN
            w_tmo_cnt_nxt = '0;
`endif
          end
        end
      end
      ACTIVE: begin
`ifdef WB_DECODER_TIMEOUT_EN
        w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
`endif
        if (!bus.wb_cyc_i) begin
          w_stb_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (bus.s_ack_i[r_idx]) begin
          w_wb_dat_nxt = bus.s_dat_i[{r_idx, 5'd0} +: DAT_W];
          w_stb_nxt    = '0;
          w_ack_nxt    = 1'b1;
          w_state_nxt  = DONE;
        end
`ifdef WB_DECODER_TIMEOUT_EN
        // An ack in the final allowed cycle takes the branch above and wins
        else if (w_tmo_cnt_nxt == TIMEOUT_CYCLES) begin
          w_wb_dat_nxt  = ERR_DATA;
          w_stb_nxt     = '0;
          w_ack_nxt     = 1'b1;
          w_state_nxt   = DONE;
          w_err_nxt     = 1'b1;
          w_last_nxt    = r_idx;
          w_err_cnt_nxt = (r_err_cnt == {ECW{1'b1}}) ? r_err_cnt : r_err_cnt + 16'd1;
        end
`endif
      end
      DONE: begin
        // A STAT access spends one extra cycle here before its ack
        if (r_ack) begin
          w_state_nxt = IDLE;
        end else begin
          w_ack_nxt = 1'b1;
          if (!r_we) begin
            w_wb_dat_nxt = w_stat_val;
          end
`ifdef WB_DECODER_TIMEOUT_EN
          else if (r_sel[0] && r_dat[0]) begin
            w_err_nxt     = 1'b0;
            w_err_cnt_nxt = '0;
            w_last_nxt    = '0;
          end
`endif
        end
      end
      default: begin
        w_stb_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adr    <= '0;
      r_dat    <= '0;
      r_sel    <= '0;
      r_we     <= 1'b0;
      r_idx    <= '0;
      r_stb    <= '0;
      r_ack    <= 1'b0;
      r_wb_dat <= '0;
    end else begin
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_sel    <= w_sel_nxt;
      r_we     <= w_we_nxt;
      r_idx    <= w_idx_nxt;
      r_stb    <= w_stb_nxt;
      r_ack    <= w_ack_nxt;
      r_wb_dat <= w_wb_dat_nxt;
    end
  end

`ifdef WB_DECODER_TIMEOUT_EN
  // Timeout counter and error status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_last    <= '0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_err     <= w_err_nxt;
      r_err_cnt <= w_err_cnt_nxt;
      r_last    <= w_last_nxt;
    end
  end
`endif

  assign bus.wb_dat_o = r_wb_dat;
  assign bus.wb_ack_o = r_ack;
  assign bus.s_adr_o  = r_adr;
  assign bus.s_dat_o  = r_dat;
  assign bus.s_sel_o  = r_sel;
  assign bus.s_we_o   = r_we;
  assign bus.s_stb_o  = r_stb;
  assign bus.s_cyc_o  = r_stb;
endmodule

// File: tb/tb_wb_addr_decoder.sv
// Scoreboard bench for wb_addr_decoder; timeout scenarios run when
// WB_DECODER_TIMEOUT_EN is defined.
module tb_wb_addr_decoder;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    string       name;
  } exp_t;
  exp_t sb_q[$];

  wb_addr_decoder_if bus_if ();

  wb_addr_decoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every upstream ack must match the oldest expected response
  always @(negedge clk) begin
    if (reset_n && bus_if.wb_ack_o === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: actual=ack expected=no_ack");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk_data && bus_if.wb_dat_o !== e.data) begin
          errors++;
          $display("FAIL %s_rdata: actual=%0h expected=%0h", e.name, bus_if.wb_dat_o, e.data);
        end
      end
    end
  end

  task automatic drive_req(input logic [35:0] adr, input logic [31:0] wdat, input logic we);
    bus_if.wb_adr_i = adr;
    bus_if.wb_dat_i = wdat;
    bus_if.wb_sel_i = 4'hF;
    bus_if.wb_we_i  = we;
    bus_if.wb_cyc_i = 1'b1;
    bus_if.wb_stb_i = 1'b1;
  endtask

  task automatic drop_req();
    bus_if.wb_cyc_i = 1'b0;
    bus_if.wb_stb_i = 1'b0;
    bus_if.wb_we_i  = 1'b0;
  endtask

  // External access: slave slot idx acks after ack_dly further ACTIVE cycles
  task automatic do_ext(input string nm, input logic [35:0] adr, input logic [31:0] wdat,
                        input logic we, input int idx, input logic [3:0] exp_stb,
                        input int ack_dly, input logic [31:0] rdat, input logic noise);
    exp_t e;
    e.data = rdat; e.chk_data = !we; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive_req(adr, wdat, we);
    @(posedge clk); #1;
    chk({nm, "_stb"}, 64'(bus_if.s_stb_o), 64'(exp_stb));
    chk({nm, "_cyc"}, 64'(bus_if.s_cyc_o), 64'(exp_stb));
    chk({nm, "_adr"}, 64'(bus_if.s_adr_o), 64'(adr));
    chk({nm, "_we"},  64'(bus_if.s_we_o),  64'(we));
    if (we) chk({nm, "_sdat"}, 64'(bus_if.s_dat_o), 64'(wdat));
    bus_if.s_ack_i = noise ? ~exp_stb : 4'b0000;
    repeat (ack_dly) @(posedge clk);
    #1;
    chk({nm, "_no_early_ack"}, 64'(bus_if.wb_ack_o), 64'd0);
    bus_if.s_dat_i = {4{32'hCCCC_CCCC}};
    bus_if.s_dat_i[idx*32 +: 32] = rdat;
    bus_if.s_ack_i = exp_stb;
    @(posedge clk); #1;
    bus_if.s_ack_i = 4'b0000;
    chk({nm, "_ack"}, 64'(bus_if.wb_ack_o), 64'd1);
    chk({nm, "_stb_drop"}, 64'(bus_if.s_stb_o), 64'd0);
    drop_req();
    @(posedge clk); #1;
    chk({nm, "_ack_single"}, 64'(bus_if.wb_ack_o), 64'd0);
  endtask

  task automatic do_stat(input string nm, input logic we, input logic [31:0] wdat,
                         input logic [31:0] exp_rdat);
    exp_t e;
    e.data = exp_rdat; e.chk_data = !we; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive_req(36'hF_FFFF_FFF0, wdat, we);
    @(posedge clk); #1;
    chk({nm, "_ack_lat1"}, 64'(bus_if.wb_ack_o), 64'd0);
    chk({nm, "_no_stb"}, 64'(bus_if.s_stb_o), 64'd0);
    @(posedge clk); #1;
    chk({nm, "_ack_lat2"}, 64'(bus_if.wb_ack_o), 64'd1);
    drop_req();
    @(posedge clk); #1;
    chk({nm, "_ack_single"}, 64'(bus_if.wb_ack_o), 64'd0);
  endtask

`ifdef WB_DECODER_TIMEOUT_EN
  task automatic do_timeout(input string nm);
    exp_t e;
    e.data = 32'hDEADBEEF; e.chk_data = 1'b1; e.name = nm;
    sb_q.push_back(e);
    @(posedge clk); #1;
    drive_req(36'hC_0000_0010, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk({nm, "_stb"}, 64'(bus_if.s_stb_o), 64'h8);
    repeat (63) @(posedge clk);
    #1;
    chk({nm, "_no_ack_c64"}, 64'(bus_if.wb_ack_o), 64'd0);
    chk({nm, "_stb_c64"}, 64'(bus_if.s_stb_o), 64'h8);
    @(posedge clk); #1;
    chk({nm, "_ack"}, 64'(bus_if.wb_ack_o), 64'd1);
    chk({nm, "_stb_drop"}, 64'(bus_if.s_stb_o), 64'd0);
    drop_req();
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    bus_if.wb_adr_i = '0;
    bus_if.wb_dat_i = '0;
    bus_if.wb_sel_i = '0;
    drop_req();
    bus_if.s_dat_i = '0;
    bus_if.s_ack_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",  64'(bus_if.wb_ack_o), 64'd0);
    chk("rst_rdat", 64'(bus_if.wb_dat_o), 64'd0);
    chk("rst_stb",  64'(bus_if.s_stb_o),  64'd0);
    chk("rst_adr",  64'(bus_if.s_adr_o),  64'd0);
    reset_n = 1'b1;

    do_ext("rd_s0", 36'h0_0000_0100, 32'h0, 1'b0, 0, 4'b0001, 3, 32'h1234_5678, 1'b1);
    do_ext("wr_s2", 36'h8_0000_0004, 32'hA5A5_A5A5, 1'b1, 2, 4'b0100, 1, 32'h0, 1'b0);
`ifdef WB_DECODER_TIMEOUT_EN
    do_timeout("tmo_s3");
    do_stat("stat_after_tmo", 1'b0, 32'h0, 32'h0001_0019);
    do_stat("stat_clr", 1'b1, 32'h0000_0001, 32'h0);
    do_stat("stat_cleared", 1'b0, 32'h0, 32'h0);
    do_ext("rd_s1_edge", 36'h4_0000_0020, 32'h0, 1'b0, 1, 4'b0010, 63, 32'h0BAD_F00D, 1'b0);
    do_stat("stat_after_edge", 1'b0, 32'h0, 32'h0);
`else
    do_stat("stat_rd", 1'b0, 32'h0, 32'h0);
    do_stat("stat_wr", 1'b1, 32'hFFFF_FFFF, 32'h0);
    do_ext("rd_s1_long", 36'h4_0000_0020, 32'h0, 1'b0, 1, 4'b0010, 100, 32'h0BAD_F00D, 1'b0);
    do_stat("stat_rd2", 1'b0, 32'h0, 32'h0);
`endif

    // Abort: cyc drops two cycles into an ACTIVE slave2 access
    @(posedge clk); #1;
    drive_req(36'h8_0000_0100, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("abort_stb_on", 64'(bus_if.s_stb_o), 64'h4);
    @(posedge clk); #1;
    drop_req();
    @(posedge clk); #1;
    chk("abort_stb_off", 64'(bus_if.s_stb_o), 64'd0);
    chk("abort_no_ack", 64'(bus_if.wb_ack_o), 64'd0);
    do_ext("rd_s2_post_abort", 36'h8_0000_0200, 32'h0, 1'b0, 2, 4'b0100, 2, 32'h2222_ABCD, 1'b0);

    // Asynchronous reset in the middle of an ACTIVE access
    @(posedge clk); #1;
    drive_req(36'h0_0000_0040, 32'h0, 1'b0);
    @(posedge clk); #1;
    chk("rst_mid_stb_on", 64'(bus_if.s_stb_o), 64'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_stb",  64'(bus_if.s_stb_o),  64'd0);
    chk("rst_mid_cyc",  64'(bus_if.s_cyc_o),  64'd0);
    chk("rst_mid_adr",  64'(bus_if.s_adr_o),  64'd0);
    chk("rst_mid_rdat", 64'(bus_if.wb_dat_o), 64'd0);
    chk("rst_mid_ack",  64'(bus_if.wb_ack_o), 64'd0);
    drop_req();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    do_ext("rd_s0_post_rst", 36'h0_0000_0080, 32'h0, 1'b0, 0, 4'b0001, 0, 32'hCAFE_0001, 1'b0);
    do_ext("rd_s3_noise", 36'hC_0000_0000, 32'h0, 1'b0, 3, 4'b1000, 2, 32'h55AA_33CC, 1'b1);

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_addr_decoder.md
WB_ADDR_DECODER -- requirements
Module: wb_addr_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8'd64: slave cycles allowed before bus-error termination.
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF: read data returned on timeout.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 wb_adr_i  in  36; wb_dat_i  in  32; wb_sel_i  in  4; wb_we_i, wb_stb_i, wb_cyc_i  in  1 each: upstream Wishbone classic slave port, fed by the LIMB bridge master.
REQ-006 wb_dat_o  out  32; wb_ack_o  out  1: upstream response.
REQ-007 s_adr_o  out  36; s_dat_o  out  32; s_sel_o  out  4; s_we_o  out  1: shared downstream request, registered.
REQ-008 s_stb_o, s_cyc_o  out  4: one-hot per downstream slave.
REQ-009 s_dat_i  in  128 (slave n at [32n+:32]); s_ack_i  in  4: downstream responses.

Function
REQ-010 Slave index is wb_adr_i[35:34]. Exception: wb_adr_i == 36'hF_FFFF_FFF0 selects the internal status register STAT.
REQ-011 States: IDLE, ACTIVE, DONE.
REQ-012 IDLE: on wb_cyc_i & wb_stb_i, register adr/dat/sel/we and index. External target: go ACTIVE, s_stb_o/s_cyc_o[index] = 1 from the next cycle. STAT target: go DONE.
REQ-013 ACTIVE: on s_ack_i[index] = 1, capture s_dat_i[index] into wb_dat_o, drop s_stb_o/s_cyc_o, go DONE. s_ack_i bits of unselected slaves are ignored.
REQ-014 DONE: wb_ack_o = 1 for exactly one cycle, then go IDLE. The cycle after DONE is IDLE, so a still-asserted stale wb_stb_i is accepted no earlier than 2 cycles after the ack.
REQ-015 Latency: external access, ack 1 cycle after s_ack_i is sampled. STAT access, ack 2 cycles after the request is sampled.
REQ-016 If wb_cyc_i falls in ACTIVE, abort: drop s_stb_o/s_cyc_o next cycle, go IDLE, no wb_ack_o.
REQ-017 STAT read = {err_count[15:0], 11'b0, last_slave[1:0], 2'b0, err}. STAT write with wb_sel_i[0] & wb_dat_i[0] = 1 clears err, err_count and last_slave. Other bits are read-only.
REQ-018 Timeout counter: cleared on entry to ACTIVE, +1 per ACTIVE cycle. When it equals TIMEOUT_CYCLES with no ack:
  - drop s_stb_o/s_cyc_o
  - wb_dat_o = ERR_DATA
  - err = 1, last_slave = index, err_count += 1 (saturating at 16'hFFFF)
  - go DONE.
REQ-019 If s_ack_i[index] and timeout occur in the same cycle, the ack wins and no error is recorded.
REQ-020 A timed-out write still returns wb_ack_o; the write is considered lost.
REQ-021 wb_dat_o holds its value between accesses. For writes, the value of wb_dat_o is unspecified.
REQ-022 At most one s_stb_o bit is ever high.

Reset
REQ-023 While reset_n = 0, the following are 0: state (IDLE), all s_* outputs, wb_ack_o, wb_dat_o, err, err_count, last_slave and the timeout counter.
REQ-024 Reset mid-access aborts with no ack. The first access after release is accepted normally.

Configuration
REQ-025 Macro WB_DECODER_TIMEOUT_EN defined: the timeout counter and REQ-018/019 are present.
REQ-026 Macro WB_DECODER_TIMEOUT_EN undefined:
  - ACTIVE waits for ack indefinitely; no counter logic is synthesized.
  - STAT reads 32'h0; STAT writes are acked and ignored.

Verification
REQ-027 Read 36'h0_0000_0100, slave0 acks 3 cycles later with 32'h12345678 -> s_stb_o = 4'b0001; wb_ack_o pulses once 1 cycle after ack; wb_dat_o = 32'h12345678.
REQ-028 Write 32'hA5A5A5A5 to 36'h8_0000_0004 -> s_stb_o = 4'b0100, s_we_o = 1, s_dat_o = 32'hA5A5A5A5; single wb_ack_o pulse.
REQ-029 (TIMEOUT_EN) Read slave3, no ack -> wb_ack_o after 64 ACTIVE cycles with data 32'hDEADBEEF. STAT read then = 32'h0001_0019 (err_count 1, last_slave 3, err 1). Write 1 to STAT -> STAT reads 32'h0.
REQ-030 (TIMEOUT_EN) Slave1 acks on exactly the 64th ACTIVE cycle -> real data returned; STAT err stays 0.
REQ-031 Drop wb_cyc_i 2 cycles into an ACTIVE slave2 access -> s_stb_o = 0 next cycle; no wb_ack_o; next access proceeds normally.
REQ-032 Assert reset_n = 0 during ACTIVE -> all outputs 0 asynchronously. After release, a slave0 read completes normally.
